// File: rtl/get_certificate_sequencer_pkg.sv
// get_certificate_sequencer_pkg: shared message constants, FSM states, error codes and per-slot certificate tables
package get_certificate_sequencer_pkg;
  localparam int MSG_LEN = 96;
  localparam int PAYLOAD_LEN = MSG_LEN - 32;
  localparam int HDR_W = 8;
  localparam logic [7:0] PROTOCOL_VERSION = 8'h12;
  localparam logic [7:0] GET_CERTIFICATE_CMD = 8'h82;
  localparam logic [3:0] SLOT0_CERT_COUNT = 4'd6;
  localparam logic [3:0] SLOT1_CERT_COUNT = 4'd4;
  localparam logic [3:0] SLOT2_CERT_COUNT = 4'd5;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DELIVER, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_INVALID_SLOT, ERR_INVALID_REQ, ERR_TIMEOUT} err_t;
  // indexed [slot][idx]; slot 3 and unmapped indices are zero
  localparam logic [3:0][7:0][15:0] CERT_LEN = {
    128'h0,
    {16'h0, 16'h0, 16'h0, 16'h0190, 16'h0480, 16'h0333, 16'h0222, 16'h0100},
    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0444, 16'h05F0, 16'h0120, 16'h0300},
    {16'h0, 16'h0, 16'h0088, 16'h07A0, 16'h0150, 16'h0410, 16'h0340, 16'h0200}
  };
  localparam logic [3:0][3:0] CERT_COUNT = {4'd0, SLOT2_CERT_COUNT, SLOT1_CERT_COUNT, SLOT0_CERT_COUNT};
endpackage

// File: rtl/get_certificate_sequencer_cert_length_table.sv
// cert_length_table: combinational (slot, idx) -> chain count and certificate length
//   i_slot   slot number      i_idx    chain index
//   o_count  certificates in the slot's chain (0 for unknown slots)
//   o_length length of entry idx (0 when unmapped)
module cert_length_table
  import get_certificate_sequencer_pkg::*;
(
  input  logic [HDR_W-1:0] i_slot,
  input  logic [3:0]       i_idx,
  output logic [3:0]       o_count,
  output logic [15:0]      o_length
);
  always_comb begin
    o_count = (i_slot < 8'd3) ? CERT_COUNT[i_slot[1:0]] : 4'd0;
    // idx < count <= 6 guarantees idx[3] is clear when the entry is used
    o_length = (i_idx < o_count) ? CERT_LEN[i_slot[1:0]][i_idx[2:0]] : 16'h0;
  end
endmodule

// File: rtl/get_certificate_sequencer.sv
// get_certificate_sequencer: fetches a slot's certificate chain one GET_CERTIFICATE per index
//   Optional feature: CERT_SEQ_RETRY_EN re-issues a timed-out request up to MAX_RETRIES times.
//   i_start/i_abort/i_slot           host control      o_busy/o_done/o_error/o_err_code  host status
//   o_req_msg/o_req_valid/i_req_ready  request bus
//   i_resp_valid/i_resp_err/i_resp_payload  responder answer
//   o_cert_data/o_cert_idx/o_cert_valid/i_cert_ready  chain buffer output
module get_certificate_sequencer
  import get_certificate_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_RETRIES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [HDR_W-1:0]       i_slot,
  output logic [MSG_LEN-1:0]     o_req_msg,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  input  logic                   i_resp_valid,
  input  logic                   i_resp_err,
  input  logic [PAYLOAD_LEN-1:0] i_resp_payload,
  output logic [PAYLOAD_LEN-1:0] o_cert_data,
  output logic [3:0]             o_cert_idx,
  output logic                   o_cert_valid,
  input  logic                   i_cert_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [1:0]             o_err_code
);
  state_t r_state, w_next;
  logic [HDR_W-1:0] r_slot, w_tbl_slot;
  logic [3:0] r_idx, w_count;
  logic [15:0] r_timer, w_length;
  logic [PAYLOAD_LEN-1:0] r_cert_data;
  logic [1:0] r_err_code;
  logic w_expire, w_last, w_can_retry, w_launch;
  // in IDLE the table is looked up with the incoming slot to decide the first transition
  assign w_tbl_slot = (r_state == S_IDLE) ? i_slot : r_slot;
  assign w_expire = r_timer == 16'd1;
  assign w_last = r_idx == w_count - 4'd1;
  assign w_launch = r_state == S_IDLE && i_start && !i_abort;
  cert_length_table u_tbl (.i_slot(w_tbl_slot), .i_idx(r_idx), .o_count(w_count), .o_length(w_length));
`ifdef CERT_SEQ_RETRY_EN
  logic [7:0] r_retries;
  assign w_can_retry = r_retries < 8'(MAX_RETRIES);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_retries <= 8'd0;
    else if (w_launch || (r_state == S_DELIVER && i_cert_ready)) r_retries <= 8'd0;
    else if (r_state == S_WAIT && w_next == S_REQ) r_retries <= r_retries + 8'd1;
`else
  // without retries a timeout is always final; the comparison keeps MAX_RETRIES referenced
  assign w_can_retry = MAX_RETRIES < 0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = (i_slot > 8'd2) ? S_ERR : (w_count == 4'd0) ? S_DONE : S_REQ;
      S_REQ:     if (i_req_ready) w_next = S_WAIT;
      S_WAIT:    if (i_resp_valid) w_next = i_resp_err ? S_ERR : S_DELIVER;
                 else if (w_expire) w_next = w_can_retry ? S_REQ : S_ERR;
      S_DELIVER: if (i_cert_ready) w_next = w_last ? S_DONE : S_REQ;
      default:   w_next = S_IDLE;
    endcase
    if (i_abort) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_slot <= '0;
      r_idx <= 4'd0;
      r_timer <= 16'd0;
      r_cert_data <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_launch) begin
        r_slot <= i_slot;
        r_idx <= 4'd0;
        r_err_code <= (i_slot > 8'd2) ? ERR_INVALID_SLOT : ERR_NONE;
      end
      if (r_state == S_REQ && i_req_ready) r_timer <= TIMEOUT_CYCLES[15:0];
      else if (r_state == S_WAIT) r_timer <= r_timer - 16'd1;
      if (r_state == S_WAIT && w_next == S_DELIVER) r_cert_data <= i_resp_payload;
      if (r_state == S_WAIT && w_next == S_ERR) r_err_code <= i_resp_valid ? ERR_INVALID_REQ : ERR_TIMEOUT;
      if (r_state == S_DELIVER && w_next == S_REQ) r_idx <= r_idx + 4'd1;
    end
  always_comb begin
    o_req_valid = r_state == S_REQ;
    o_cert_valid = r_state == S_DELIVER;
    o_busy = r_state != S_IDLE;
    o_done = r_state == S_DONE;
    o_error = r_state == S_ERR;
    o_req_msg = (r_state == S_REQ) ?
      {PROTOCOL_VERSION, GET_CERTIFICATE_CMD, r_slot, 8'h00, 12'h000, r_idx, w_length, {(MSG_LEN-64){1'b0}}} : '0;
  end
  assign o_cert_data = r_cert_data;
  assign o_cert_idx = r_idx;
  assign o_err_code = r_err_code;
endmodule

// File: tb/tb_get_certificate_sequencer.sv
// tb_get_certificate_sequencer: vector table plus random chains checked against a chain-level model
module tb_get_certificate_sequencer;
  localparam int TO = 8;
`ifdef CERT_SEQ_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif
  logic clk = 0, rst_n = 0;
  logic i_start = 0, i_abort = 0, i_req_ready = 0, i_resp_valid = 0, i_resp_err = 0, i_cert_ready = 0;
  logic [7:0] i_slot = 0;
  logic [63:0] i_resp_payload = 0;
  logic [95:0] o_req_msg;
  logic [63:0] o_cert_data;
  logic [3:0] o_cert_idx;
  logic [1:0] o_err_code;
  logic o_req_valid, o_cert_valid, o_busy, o_done, o_error;
  always #5 clk = ~clk;
  get_certificate_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_slot(i_slot),
    .o_req_msg(o_req_msg), .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_err(i_resp_err), .i_resp_payload(i_resp_payload),
    .o_cert_data(o_cert_data), .o_cert_idx(o_cert_idx), .o_cert_valid(o_cert_valid),
    .i_cert_ready(i_cert_ready), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_err_code(o_err_code));
  typedef struct {int slot; int err; int silent; int stall; int abrt; int lat; bit rnd; int code;} vec_t;
  int len_tab[3][6] = '{'{'h200, 'h340, 'h410, 'h150, 'h7A0, 'h88},
                        '{'h300, 'h120, 'h5F0, 'h444, 0, 0},
                        '{'h100, 'h222, 'h333, 'h480, 'h190, 0}};
  int cnt_tab[3] = '{6, 4, 5};
  int checks = 0, errors = 0;
  logic [95:0] exp_req[$], got_req[$];
  logic [67:0] exp_dlv[$], got_dlv[$];
  vec_t vecs[27];
  function automatic logic [63:0] pay(input int unsigned seed, input int i);
    return {seed, seed ^ (32'(i) * 32'h9E3779B9)};
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // chain-level expectation: code 0 done, 1..3 error code, 4 aborted
  task automatic model(input vec_t v, input int unsigned seed, output int code);
    exp_req.delete();
    exp_dlv.delete();
    code = 0;
    if (v.slot > 2) begin
      code = 1;
      return;
    end
    for (int i = 0; i < cnt_tab[v.slot]; i++) begin
      logic [95:0] m;
      m = {8'h12, 8'h82, 8'(v.slot), 8'h00, 16'(i), 16'(len_tab[v.slot][i]), 32'h0};
      if (i == v.silent) begin
        repeat (1 + RETRIES) exp_req.push_back(m);
        code = 3;
        return;
      end
      exp_req.push_back(m);
      if (i == v.abrt) begin
        code = 4;
        return;
      end
      if (i == v.err) begin
        code = 2;
        return;
      end
      exp_dlv.push_back({4'(i), pay(seed, i)});
    end
  endtask
  task automatic run(input vec_t v);
    int unsigned seed;
    int cd, pend, stall_cnt, code, act, act_c;
    bit abort_next;
    seed = $urandom;
    cd = 0; pend = 0; stall_cnt = 0; act = -1; act_c = -1; abort_next = 0;
    got_req.delete();
    got_dlv.delete();
    @(negedge clk);
    i_slot = 8'(v.slot);
    i_start = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      i_start = 0; i_resp_valid = 0; i_resp_err = 0;
      if (o_done) begin
        act = 0;
        chk("done_err_code", o_err_code, 0);
        break;
      end
      if (o_error) begin
        act = int'(o_err_code);
        act_c = c;
        break;
      end
      if (abort_next) begin
        i_abort = 1;
        act = 4;
        break;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_resp_valid = 1;
          i_resp_err = pend == v.err;
          i_resp_payload = pay(seed, pend);
        end
      end
      i_req_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      i_cert_ready = 1;
      if (o_cert_valid && int'(o_cert_idx) == v.stall && stall_cnt < 10) begin
        i_cert_ready = 0;
        stall_cnt++;
        chk("stall_data", o_cert_data, pay(seed, v.stall));
        chk("stall_no_req", o_req_valid, 0);
        if (stall_cnt == 3) begin
          i_resp_valid = 1;
          i_resp_payload = ~pay(seed, v.stall);
        end
      end
      if (o_req_valid && i_req_ready) begin
        got_req.push_back(o_req_msg);
        pend = int'(o_req_msg[63:48]);
        cd = (pend == v.silent) ? 0 : (v.lat > 0) ? v.lat : int'($urandom_range(1, 4));
        abort_next = pend == v.abrt;
      end
      if (o_cert_valid && i_cert_ready) got_dlv.push_back({o_cert_idx, o_cert_data});
    end
    if (act < 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: slot %0d got no done/error within 400 cycles", v.slot);
    end
    model(v, seed, code);
    chk("outcome", act, v.code);
    chk("req_count", got_req.size(), exp_req.size());
    for (int i = 0; i < exp_req.size() && i < got_req.size(); i++) chk("req_msg", got_req[i], exp_req[i]);
    chk("dlv_count", got_dlv.size(), exp_dlv.size());
    for (int i = 0; i < exp_dlv.size() && i < got_dlv.size(); i++) chk("dlv", got_dlv[i], exp_dlv[i]);
    if (v.slot > 2) chk("slot_err_latency", act_c, 0);
    @(negedge clk);
    i_abort = 0;
    chk("post_busy", o_busy, 0);
    chk("post_done", o_done, 0);
    chk("post_error", o_error, 0);
    if (code >= 1 && code <= 3) chk("err_code_hold", o_err_code, code);
    if (act == 4) begin
      chk("abort_err_code", o_err_code, 0);
      chk("abort_req_valid", o_req_valid, 0);
      i_resp_valid = 1;
      i_resp_payload = '1;
      @(negedge clk);
      i_resp_valid = 0;
      chk("late_resp_busy", o_busy, 0);
      chk("late_resp_cert", o_cert_valid, 0);
    end
  endtask
  initial begin
    vec_t v;
    int e, dummy;
    vecs[0] = '{0, -1, -1, -1, -1, 3, 1'b0, 0};
    vecs[1] = '{3, -1, -1, -1, -1, 3, 1'b0, 1};
    vecs[2] = '{1, 2, -1, -1, -1, 2, 1'b0, 2};
    vecs[3] = '{2, -1, 0, -1, -1, 2, 1'b0, 3};
    vecs[4] = '{2, -1, -1, 1, -1, 2, 1'b0, 0};
    vecs[5] = '{2, -1, -1, -1, 2, 2, 1'b0, 4};
    vecs[6] = '{0, -1, -1, -1, -1, 1, 1'b1, 0};
    for (int i = 7; i < 27; i++) begin
      v.slot = int'($urandom_range(0, 3));
      e = int'($urandom_range(0, 9));
      v.err = (e < 6) ? e : -1;
      v.silent = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : -1;
      v.stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1;
      v.abrt = -1;
      v.lat = 0;
      v.rnd = 1;
      model(v, 0, dummy);
      v.code = dummy;
      vecs[i] = v;
    end
    #12;
    chk("rst_req_msg", o_req_msg, 0);
    chk("rst_req_valid", o_req_valid, 0);
    chk("rst_cert_valid", o_cert_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_cert_data", o_cert_data, 0);
    chk("rst_cert_idx", o_cert_idx, 0);
    chk("rst_err_code", o_err_code, 0);
    @(negedge clk);
    rst_n = 1;
    foreach (vecs[i]) run(vecs[i]);
    @(negedge clk);
    i_slot = 8'd0;
    i_start = 1;
    i_req_ready = 1;
    @(negedge clk);
    i_start = 0;
    repeat (3) @(negedge clk);
    chk("midfetch_busy", o_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", o_busy, 0);
    chk("async_rst_req", o_req_valid, 0);
    chk("async_rst_idx", o_cert_idx, 0);
    @(negedge clk);
    rst_n = 1;
    i_resp_valid = 1;
    i_resp_payload = 64'h1234;
    @(negedge clk);
    i_resp_valid = 0;
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_cert", o_cert_valid, 0);
    chk("post_rst_data", o_cert_data, 0);
    run(vecs[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
